data_sync: RTL and testbench

//  Clock-domain-crossing synchronizer for a multi-bit data bus qualified by a single enable bit.
//  bus_enable from the source domain passes through a 'stages'-deep flop chain into the clk domain.
//  A rising-edge detector on the synchronized enable produces one-cycle enable_pulse.
//  The same cycle, the bus (stable by protocol) is captured into sync_bus.

---
 rtl/data_sync_pkg.sv | 12 +
 rtl/data_sync_bit_sync.sv | 25 ++
 rtl/data_sync.sv | 47 ++++
 tb/tb_data_sync.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared defaults and helpers for the enable-qualified bus synchronizer.
package data_sync_pkg;

    localparam int DEF_STAGES = 2;
    localparam int DEF_DATA_W = 8;

    // High for exactly one cycle when a level goes from 0 to 1.
    function automatic logic rising_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/data_sync_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module bit_sync
    import data_sync_pkg::*;
#(
    parameter int STAGES = DEF_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sff <= '0;
        end else begin
            sff <= {sff[STAGES-2:0], d};
        end
    end

    assign q = sff[STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Bus CDC: synchronizes the enable, strobes once per rising edge of it,
// and captures the protocol-stable bus on that same strobe.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_enable,
    input  logic [DATA_W-1:0] unsync_bus,
    output logic [DATA_W-1:0] sync_bus,
    output logic              enable_pulse
);

    logic sync_en;
    logic en_d;
    logic pulse_gen;

    bit_sync #(
        .STAGES(STAGES)
    ) u_bit_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus_enable),
        .q   (sync_en)
    );

    assign pulse_gen = rising_edge(sync_en, en_d);

    // Stage boundary: edge detect, strobe and data capture share one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d         <= 1'b0;
            enable_pulse <= 1'b0;
            sync_bus     <= '0;
        end else begin
            en_d         <= sync_en;
            enable_pulse <= pulse_gen;
            if (pulse_gen) begin
                sync_bus <= unsync_bus;
            end
        end
    end

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync at STAGES = 2, 3 and 4 sharing one stimulus.
module tb_data_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_enable;
    logic [7:0] unsync_bus;
    logic [7:0] sb [3];
    logic       pl [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_sync #(.STAGES(2), .DATA_W(8)) u_s2 (
        .clk(clk), .rst(rst), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .sync_bus(sb[0]), .enable_pulse(pl[0]));
    data_sync #(.STAGES(3), .DATA_W(8)) u_s3 (
        .clk(clk), .rst(rst), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .sync_bus(sb[1]), .enable_pulse(pl[1]));
    data_sync #(.STAGES(4), .DATA_W(8)) u_s4 (
        .clk(clk), .rst(rst), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .sync_bus(sb[2]), .enable_pulse(pl[2]));

    typedef struct {
        logic [7:0] data;
        int         en_cycles;
        logic [7:0] exp_bus;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (stages=%0d): got %0h, expected %0h", name, idx + 2, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bus_enable is already high when called; it is dropped after en_cycles edges.
    task automatic measure(input logic [7:0] data, input logic [7:0] prev,
                           input int en_cycles, input int exp_pulses, input string tag);
        int         first [3];
        int         cnt   [3];
        logic [7:0] cap   [3];
        logic       held  [3];
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; cnt[i] = 0; cap[i] = '0; held[i] = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == en_cycles) bus_enable = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (pl[i]) begin
                    cnt[i]++;
                    if (first[i] < 0) begin
                        first[i] = k;
                        cap[i]   = sb[i];
                    end
                end else if (first[i] < 0 && sb[i] !== prev) begin
                    held[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check({tag, " latency"}, i, first[i], i + 3);
            check({tag, " pulse count"}, i, cnt[i], exp_pulses);
            check({tag, " data at pulse"}, i, cap[i], data);
            check({tag, " held before pulse"}, i, held[i], 1'b1);
            check({tag, " final bus"}, i, sb[i], data);
        end
    endtask

    initial begin
        logic [7:0] last;
        logic       seen [3];
        logic [7:0] vals [10];

        vals = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'hE7};
        vecs[0] = '{8'hA5, 1, 8'hA5, 1};
        for (int j = 0; j < 10; j++) vecs[j + 1] = '{vals[j], 1, vals[j], 1};
        vecs[11] = '{8'h3C, 10, 8'h3C, 1};

        // Reset with bus_enable toggling: nothing may get through.
        rst = 1'b0; bus_enable = 1'b0; unsync_bus = 8'h00;
        tick();
        unsync_bus = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            bus_enable = ~bus_enable;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("reset sync_bus", i, sb[i], 8'h00);
            check("reset enable_pulse", i, pl[i], 1'b0);
        end
        bus_enable = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int i = 0; i < 3; i++) if (pl[i] || sb[i] !== 8'h00) seen[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) check("quiet after release", i, seen[i], 1'b0);

        // Table: single transfers then one long enable.
        last = 8'h00;
        foreach (vecs[j]) begin
            unsync_bus = vecs[j].data;
            bus_enable = 1'b1;
            measure(vecs[j].exp_bus, last, vecs[j].en_cycles, vecs[j].exp_pulses,
                    $sformatf("vec%0d", j));
            tick();
            last = vecs[j].exp_bus;
        end

        // Reset one cycle after enable: pending pulse lost, bus cleared.
        unsync_bus = 8'h99;
        bus_enable = 1'b1;
        tick();
        bus_enable = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check("async clear", i, sb[i], 8'h00);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 3; i++) if (pl[i]) seen[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            check("midflight no pulse", i, seen[i], 1'b0);
            check("midflight sync_bus", i, sb[i], 8'h00);
        end

        // Enable still high across reset release re-propagates once.
        rst = 1'b0;
        unsync_bus = 8'h42;
        bus_enable = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        measure(8'h42, 8'h00, 3, 1, "release-high");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
